// File: rtl/hazard_tnew_tracker.sv
// Tracks register writers in flight through E/M/W with a per-stage Tnew countdown,
// and from them derives the D-stage stall, the rs/rt forward selects and a stall counter.
module hazard_tnew_tracker #(
  parameter int TW    = 3,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       D_rs,
  input  logic [4:0]       D_rt,
  input  logic [TW-1:0]    D_Tuse_rs,
  input  logic [TW-1:0]    D_Tuse_rt,
  input  logic             D_RFWr,
  input  logic [4:0]       D_A3,
  input  logic [TW-1:0]    D_Tnew,
  output logic             stall,
  output logic [1:0]       fwd_rs,
  output logic [1:0]       fwd_rt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic          valid;
    logic [4:0]    a3;
    logic [TW-1:0] tnew;
  } entry_t;

  localparam entry_t EMPTY = '0;

  entry_t           e_q, e_d;
  entry_t           m_q, m_d;
  entry_t           w_q, w_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             stall_rs, stall_rt;

  // Register 0 is hard-wired, so a writer to it can never be a dependency.
  function automatic logic hit(input entry_t x, input logic [4:0] s);
    return x.valid && (x.a3 == s) && (s != 5'd0);
  endfunction

  // Only the nearest matching writer among E/M decides; W is always ready.
  function automatic logic src_stall(input entry_t e, input entry_t m,
                                     input logic [4:0] s, input logic [TW-1:0] tuse);
    if (hit(e, s)) return e.tnew > tuse;
    if (hit(m, s)) return m.tnew > tuse;
    return 1'b0;
  endfunction

  function automatic logic [1:0] src_fwd(input entry_t e, input entry_t m, input entry_t w,
                                         input logic [4:0] s);
    if (hit(e, s)) return (e.tnew == '0) ? 2'd1 : 2'd0;
    if (hit(m, s)) return (m.tnew == '0) ? 2'd2 : 2'd0;
    if (hit(w, s)) return (w.tnew == '0) ? 2'd3 : 2'd0;
    return 2'd0;
  endfunction

  always_comb begin
    stall_rs = src_stall(e_q, m_q, D_rs, D_Tuse_rs);
    stall_rt = src_stall(e_q, m_q, D_rt, D_Tuse_rt);
    stall    = stall_rs | stall_rt;
    fwd_rs   = src_fwd(e_q, m_q, w_q, D_rs);
    fwd_rt   = src_fwd(e_q, m_q, w_q, D_rt);
  end

  // NOTE: every signal written here gets a value on every path, so no latch can be inferred.
  always_comb begin
    e_d         = EMPTY;
    m_d         = e_q;
    w_d         = m_q;
    stall_cnt_d = stall_cnt_q + CNT_W'(stall);
    if (!stall) begin
      e_d.valid = D_RFWr && (D_A3 != 5'd0);
      e_d.a3    = D_A3;
      e_d.tnew  = D_Tnew;
    end
    m_d.tnew = (e_q.tnew == '0) ? '0 : e_q.tnew - TW'(1);
    w_d.tnew = '0;
  end

  // NOTE: state flops use non-blocking assignments so all stages shift on the same edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      e_q         <= EMPTY;
      m_q         <= EMPTY;
      w_q         <= EMPTY;
      stall_cnt_q <= '0;
    end else begin
      e_q         <= e_d;
      m_q         <= m_d;
      w_q         <= w_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_tnew_tracker.sv
// Directed and random checks of hazard_tnew_tracker against a writer-age reference model.
module tb_hazard_tnew_tracker;

  localparam int TW    = 3;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       D_rs, D_rt, D_A3;
  logic [TW-1:0]    D_Tuse_rs, D_Tuse_rt, D_Tnew;
  logic             D_RFWr;
  logic             stall;
  logic [1:0]       fwd_rs, fwd_rt;
  logic [CNT_W-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  hazard_tnew_tracker #(.TW(TW), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .D_rs(D_rs), .D_rt(D_rt), .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt),
    .D_RFWr(D_RFWr), .D_A3(D_A3), .D_Tnew(D_Tnew),
    .stall(stall), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: each writer is remembered with its register, its Tnew and
  // how many cycles ago it entered E (age 0 = E, 1 = M, 2 = W).
  typedef struct {
    int rd;
    int tnew;
    int age;
  } wr_t;

  wr_t q[$];
  int  model_cnt = 0;

  function automatic void model_src(input int s, input int tuse, output bit st, output int fw);
    int best;
    int rem;
    best = -1;
    st   = 0;
    fw   = 0;
    foreach (q[i])
      if (s != 0 && q[i].rd == s && (best < 0 || q[i].age < q[best].age)) best = i;
    if (best >= 0) begin
      rem = (q[best].age >= 2) ? 0 : q[best].tnew - q[best].age;
      if (rem < 0) rem = 0;
      if (q[best].age <= 1 && rem > tuse) st = 1;
      if (rem == 0) fw = q[best].age + 1;
    end
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One D-stage cycle: drive, check combinational outputs and counter, clock, update model.
  task automatic step(input string tag, input bit rst_v, input int rs, input int rt,
                      input int tuse_rs, input int tuse_rt, input bit rfwr,
                      input int a3, input int tnew);
    bit st_rs, st_rt, st;
    int fw_rs, fw_rt;
    wr_t nq[$];
    @(negedge clk);
    reset     = rst_v;
    D_rs      = 5'(rs);
    D_rt      = 5'(rt);
    D_Tuse_rs = TW'(tuse_rs);
    D_Tuse_rt = TW'(tuse_rt);
    D_RFWr    = rfwr;
    D_A3      = 5'(a3);
    D_Tnew    = TW'(tnew);
    #1;
    model_src(rs, tuse_rs, st_rs, fw_rs);
    model_src(rt, tuse_rt, st_rt, fw_rt);
    st = st_rs | st_rt;
    check({tag, ".stall"},  int'(stall),     int'(st));
    check({tag, ".fwd_rs"}, int'(fwd_rs),    fw_rs);
    check({tag, ".fwd_rt"}, int'(fwd_rt),    fw_rt);
    check({tag, ".cnt"},    int'(stall_cnt), model_cnt);
    @(posedge clk);
    if (!rst_v) begin
      q.delete();
      model_cnt = 0;
    end else begin
      foreach (q[i]) if (q[i].age < 2) nq.push_back('{q[i].rd, q[i].tnew, q[i].age + 1});
      if (!st && rfwr && a3 != 0) nq.push_back('{a3, tnew, 0});
      q = nq;
      if (st) model_cnt = (model_cnt + 1) % (1 << CNT_W);
    end
  endtask

  initial begin
    reset = 1'b0; D_rs = '0; D_rt = '0; D_Tuse_rs = 3'd3; D_Tuse_rt = 3'd3;
    D_RFWr = 1'b1; D_A3 = 5'd7; D_Tnew = '0;
    @(posedge clk);

    // Reset held two cycles with a writer present on D, then readers of that register.
    step("rst0", 0, 7, 7, 0, 0, 1, 7, 0);
    step("rst1", 0, 7, 7, 0, 0, 1, 7, 0);
    step("rel",  1, 7, 7, 0, 0, 0, 0, 0);
    step("rel2", 1, 0, 0, 3, 3, 0, 0, 0);

    // LW $8 then ADD rs=$8: one stall, then M (Tnew 1) gives 0, then W forwards.
    step("lw",    1, 0, 0, 3, 3, 1, 8, 2);
    step("add_s", 1, 8, 0, 1, 3, 1, 10, 1);
    step("add_m", 1, 8, 0, 1, 3, 1, 10, 1);
    step("add_w", 1, 8, 0, 1, 3, 0, 0, 0);
    step("idle1", 1, 0, 0, 3, 3, 0, 0, 0);

    // ADD $9 then BEQ rs=$9 (Tuse 0): one stall, then forward from M.
    step("add9",  1, 0, 0, 3, 3, 1, 9, 1);
    step("beq_s", 1, 9, 0, 0, 0, 0, 0, 0);
    step("beq_m", 1, 9, 0, 0, 0, 0, 0, 0);

    // JAL then JR $31: no stall, immediate forward from E.
    step("jal", 1, 0, 0, 3, 3, 1, 31, 0);
    step("jr",  1, 31, 0, 0, 3, 0, 0, 0);

    // Writers to $0 and a non-writing instruction naming $5 never create hazards.
    step("w0",  1, 0, 0, 3, 3, 1, 0, 2);
    step("nw5", 1, 0, 0, 3, 3, 0, 5, 2);
    step("r05", 1, 0, 5, 0, 0, 0, 0, 0);
    step("r50", 1, 5, 0, 0, 0, 0, 0, 0);

    // E and W both hold $4 (E ready): rs==rt selects E on both paths.
    step("w4a",  1, 0, 0, 3, 3, 1, 4, 0);
    step("gap",  1, 0, 0, 3, 3, 0, 0, 0);
    step("w4b",  1, 0, 0, 3, 3, 1, 4, 0);
    step("rsrt", 1, 4, 4, 0, 0, 0, 0, 0);

    // Reset while a stall is active clears every in-flight writer on that edge.
    step("lw4",   1, 0, 0, 3, 3, 1, 4, 2);
    step("mrst",  0, 4, 4, 0, 0, 0, 0, 0);
    step("post",  1, 4, 4, 0, 0, 0, 0, 0);

    // Random traffic over a few registers so matches, stalls and counter wrap occur.
    for (int i = 0; i < 400; i++) begin
      step("rnd", ($urandom_range(0, 59) != 0),
           $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 3), $urandom_range(0, 3),
           1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
